// File: rtl/int_seq_if.sv
// int_seq_if: CPU-side handshake and latch-strobe bundle for the interrupt sequencer.
// slave  = the sequencer itself, master = CPU core / bench driving it.
interface int_seq_if;
    logic       ph2_en;
    logic       res_n;
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic       sync;
    logic       vec_done;
    logic       s_n;
    logic       r1_n;
    logic       r2_n;
    logic       int_req;
    logic [1:0] vec_sel;
    logic       err_to;

    modport slave (
        input  ph2_en, res_n, nmi_n, irq_n, i_flag, sync, vec_done,
        output s_n, r1_n, r2_n, int_req, vec_sel, err_to
    );

    modport master (
        output ph2_en, res_n, nmi_n, irq_n, i_flag, sync, vec_done,
        input  s_n, r1_n, r2_n, int_req, vec_sel, err_to
    );
endinterface

// File: rtl/int_seq.sv
// int_seq: RES/NMI/IRQ request sequencer feeding the m6502 RS interrupt latch.
// Synchronises requests, arbitrates at opcode fetch (RES > NMI > IRQ), emits
// one-clock active-low set/reset strobes and the vector select.
// Optional WAIT_VEC watchdog: define INT_SEQ_TIMEOUT_EN.
module int_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic     clk,
    input  logic     rst,
    int_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TAKE, WAIT_VEC, CLEAR} state_t;

    localparam logic [1:0] V_NONE = 2'b00;
    localparam logic [1:0] V_RES  = 2'b01;
    localparam logic [1:0] V_NMI  = 2'b10;
    localparam logic [1:0] V_IRQ  = 2'b11;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_res_sync, r_nmi_sync, r_irq_sync;
    logic [SYNC_STAGES:0]   r_smp_vld;
    logic                   r_nmi_prev;
    logic                   r_res_pend, r_nmi_pend;
    logic [1:0]             r_vec_sel, w_vec_sel_nxt;
    logic                   w_res_s, w_nmi_s, w_irq_s;
    logic                   w_nmi_edge, w_irq_act, w_any_req, w_to_hit;

    assign w_res_s   = r_res_sync[SYNC_STAGES-1];
    assign w_nmi_s   = r_nmi_sync[SYNC_STAGES-1];
    assign w_irq_s   = r_irq_sync[SYNC_STAGES-1];
    // The preset 1s are not real samples: only accept an NMI edge once the
    // history flop holds a genuine post-reset sample, so NMI held low
    // through reset is never seen as a falling edge.
    assign w_nmi_edge = r_smp_vld[SYNC_STAGES] & r_nmi_prev & ~w_nmi_s;
    assign w_irq_act  = ~w_irq_s & ~bus.i_flag;
    assign w_any_req  = r_res_pend | r_nmi_pend | w_irq_act;

    // Input synchronisers, NMI edge history and sample-valid tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_sync <= '1;
            r_nmi_sync <= '1;
            r_irq_sync <= '1;
            r_nmi_prev <= 1'b1;
            r_smp_vld  <= '0;
        end else begin
            r_res_sync <= {r_res_sync[SYNC_STAGES-2:0], bus.res_n};
            r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], bus.nmi_n};
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], bus.irq_n};
            r_nmi_prev <= w_nmi_s;
            r_smp_vld  <= {r_smp_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Pending capture; a new request in the clearing clk wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_pend <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            if (r_state == CLEAR && r_vec_sel == V_RES) r_res_pend <= 1'b0;
            if (r_state == CLEAR && r_vec_sel == V_NMI) r_nmi_pend <= 1'b0;
            if (!w_res_s)   r_res_pend <= 1'b1;
            if (w_nmi_edge) r_nmi_pend <= 1'b1;
        end
    end

    // State and vector-select registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vec_sel <= V_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_vec_sel <= w_vec_sel_nxt;
        end
    end

`ifdef INT_SEQ_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYC - 1);

    logic [3:0] r_to_cnt;
    logic       r_err_to;

    // WAIT_VEC watchdog: restarts on every entry, counts CPU cycles
    always_ff @(posedge clk) begin
        if (rst || r_state == TAKE) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_VEC && bus.ph2_en) begin
            r_to_cnt <= r_to_cnt + 4'd1;
        end
    end

    // Sticky timeout flag, only rst clears it
    always_ff @(posedge clk) begin
        if (rst)           r_err_to <= 1'b0;
        else if (w_to_hit) r_err_to <= 1'b1;
    end

    assign bus.err_to = r_err_to;
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT_CYC != 0);
    assign bus.err_to  = 1'b0;
`endif

    // Next-state: arbitration in IDLE, strobe sequencing afterwards
    always_comb begin
        w_state_nxt   = r_state;
        w_vec_sel_nxt = r_vec_sel;
        w_to_hit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ph2_en && bus.sync && w_any_req) begin
                    w_state_nxt = TAKE;
                    if (r_res_pend)      w_vec_sel_nxt = V_RES;
                    else if (r_nmi_pend) w_vec_sel_nxt = V_NMI;
                    else                 w_vec_sel_nxt = V_IRQ;
                end
            end
            TAKE: w_state_nxt = WAIT_VEC;
            WAIT_VEC: begin
                if (bus.vec_done) begin
                    w_state_nxt = CLEAR;
                end
`ifdef INT_SEQ_TIMEOUT_EN
                else if (bus.ph2_en && r_to_cnt == TO_LAST) begin
                    w_state_nxt = CLEAR;
                    w_to_hit    = 1'b1;
                end
`endif
            end
            CLEAR: begin
                w_state_nxt   = IDLE;
                w_vec_sel_nxt = V_NONE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_vec_sel_nxt = V_NONE;
            end
        endcase
    end

    // Strobes decode straight from state, so only one can ever be low
    assign bus.s_n     = (r_state != TAKE);
    assign bus.r1_n    = ~(r_state == CLEAR && r_vec_sel != V_IRQ);
    assign bus.r2_n    = ~(r_state == CLEAR && r_vec_sel == V_IRQ);
    assign bus.int_req = (r_state != IDLE);
    assign bus.vec_sel = r_vec_sel;
endmodule

// File: tb/tb_int_seq.sv
// tb_int_seq: directed bench for int_seq (vector table + hand sequences).
// Output bundle order: {s_n, r1_n, r2_n, int_req, vec_sel[1:0], err_to}.
module tb_int_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    int_seq_if ifc ();

    int_seq #(.SYNC_STAGES(2), .TIMEOUT_CYC(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] O_IDLE = 7'b1110000;

    typedef struct {
        logic       ph2, res_n, nmi_n, irq_n, i_flag, sync, vec_done;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [6:0] outs();
        return {ifc.s_n, ifc.r1_n, ifc.r2_n, ifc.int_req, ifc.vec_sel, ifc.err_to};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change #1 after the active edge; outputs are read there too
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] w_exp(input logic [1:0] ev);
        return {1'b1, 1'b1, 1'b1, 1'b1, ev, 1'b0};
    endfunction

    task automatic take(input logic [1:0] ev, input string nm);
        ifc.ph2_en = 1'b1; ifc.sync = 1'b1;
        tick();
        chk({nm, " take"}, 32'(outs()), 32'({1'b0, 1'b1, 1'b1, 1'b1, ev, 1'b0}));
        ifc.ph2_en = 1'b0; ifc.sync = 1'b0;
        tick();
        chk({nm, " wait"}, 32'(outs()), 32'(w_exp(ev)));
    endtask

    task automatic finish(input logic [1:0] ev, input logic irq, input string nm);
        ifc.vec_done = 1'b1;
        tick();
        chk({nm, " clear"}, 32'(outs()), 32'({1'b1, irq, ~irq, 1'b1, ev, 1'b0}));
        ifc.vec_done = 1'b0;
        tick();
        chk({nm, " idle"}, 32'(outs()), 32'(O_IDLE));
    endtask

    task automatic sync_idle(input string nm);
        ifc.ph2_en = 1'b1; ifc.sync = 1'b1;
        tick();
        chk(nm, 32'(outs()), 32'(O_IDLE));
        ifc.ph2_en = 1'b0; ifc.sync = 1'b0;
    endtask

    // Fresh NMI edge and its pend captured
    task automatic nmi_edge();
        ifc.nmi_n = 1'b1; tick(3);
        ifc.nmi_n = 1'b0; tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        //            ph2 res nmi irq if  syn vd  expected
        tbl[0] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, O_IDLE};
        tbl[1] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, O_IDLE};
        tbl[2] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, O_IDLE};      // pend lands this edge
        tbl[3] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 7'b0111100}; // TAKE
        tbl[4] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 7'b1111100}; // WAIT_VEC
        tbl[5] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 7'b1111100};
        tbl[6] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 7'b1011100}; // CLEAR r1_n
        tbl[7] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, O_IDLE};
        tbl[8] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, O_IDLE};      // pend consumed
        tbl[9] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, O_IDLE};      // stray vec_done

        // Reset with NMI already low
        ifc.ph2_en = 1'b0; ifc.res_n = 1'b1; ifc.nmi_n = 1'b0; ifc.irq_n = 1'b1;
        ifc.i_flag = 1'b0; ifc.sync = 1'b0; ifc.vec_done = 1'b0;
        tick(3);
        chk("reset outs", 32'(outs()), 32'(O_IDLE));
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            ifc.ph2_en = (i % 4 == 3); ifc.sync = (i % 4 == 3);
            tick();
            if (outs() !== O_IDLE) bad++;
        end
        chk("nmi held thru reset", 32'(bad), 32'd0);
        ifc.ph2_en = 1'b0; ifc.sync = 1'b0;
        ifc.nmi_n = 1'b1;
        tick(5);

        // Cycle-accurate NMI service
        for (int i = 0; i < 10; i++) begin
            ifc.ph2_en = tbl[i].ph2;   ifc.res_n = tbl[i].res_n; ifc.nmi_n = tbl[i].nmi_n;
            ifc.irq_n  = tbl[i].irq_n; ifc.i_flag = tbl[i].i_flag; ifc.sync = tbl[i].sync;
            ifc.vec_done = tbl[i].vec_done;
            tick();
            chk($sformatf("nmi row %0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        ifc.ph2_en = 1'b0; ifc.sync = 1'b0; ifc.vec_done = 1'b0;
        ifc.nmi_n = 1'b1;
        tick(4);

        // All three pending at one sync: RES, then NMI, then IRQ
        ifc.res_n = 1'b0; ifc.nmi_n = 1'b0; ifc.irq_n = 1'b0; ifc.i_flag = 1'b0;
        tick(4);
        ifc.res_n = 1'b1;
        tick(4);
        take(2'b01, "prio res");
        finish(2'b01, 1'b0, "prio res");
        take(2'b10, "prio nmi");
        finish(2'b10, 1'b0, "prio nmi");
        take(2'b11, "prio irq");
        ifc.irq_n = 1'b1;
        finish(2'b11, 1'b1, "prio irq");
        tick(4);
        sync_idle("prio leftovers");

        // IRQ masked by i_flag across 20 syncs, then unmasked
        ifc.irq_n = 1'b0; ifc.i_flag = 1'b1;
        tick(3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ifc.ph2_en = 1'b1; ifc.sync = 1'b1;
            tick();
            if (outs() !== O_IDLE) bad++;
            ifc.ph2_en = 1'b0; ifc.sync = 1'b0;
            tick();
        end
        chk("irq masked", 32'(bad), 32'd0);
        ifc.i_flag = 1'b0;
        take(2'b11, "irq unmasked");
        ifc.irq_n = 1'b1;
        finish(2'b11, 1'b1, "irq unmasked");
        tick(4);

        // IRQ released before sync: dropped
        ifc.irq_n = 1'b0; tick(2);
        ifc.irq_n = 1'b1; tick(4);
        sync_idle("irq dropped");

        // New NMI edge in the clk its pend clears: stays pending
        nmi_edge();
        take(2'b10, "nmi race");
        ifc.nmi_n = 1'b1; tick(3);
        ifc.nmi_n = 1'b0; tick();
        ifc.vec_done = 1'b1; tick();
        chk("nmi race clear", 32'(outs()), 32'(7'b1011100));
        ifc.vec_done = 1'b0; tick();
        chk("nmi race idle", 32'(outs()), 32'(O_IDLE));
        take(2'b10, "nmi reedge");
        finish(2'b10, 1'b0, "nmi reedge");

        // RES during NMI WAIT_VEC: NMI completes first
        nmi_edge();
        take(2'b10, "res late");
        ifc.res_n = 1'b0; tick(4);
        ifc.res_n = 1'b1; tick(3);
        chk("res late hold", 32'(outs()), 32'(w_exp(2'b10)));
        finish(2'b10, 1'b0, "res late nmi");
        take(2'b01, "res late res");
        finish(2'b01, 1'b0, "res late res");

        // Long WAIT_VEC without vec_done
        nmi_edge();
        take(2'b10, "long wait");
`ifdef INT_SEQ_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            ifc.ph2_en = 1'b1;
            tick();
            if (i < 15) chk($sformatf("to wait %0d", i), 32'(outs()), 32'(w_exp(2'b10)));
            else        chk("to clear", 32'(outs()), 32'(7'b1011101));
        end
        ifc.ph2_en = 1'b0;
        tick();
        chk("to idle err", 32'(outs()), 32'(7'b1110001));
        tick(3);
        chk("to err sticky", 32'(outs()), 32'(7'b1110001));
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        chk("to err rst", 32'(outs()), 32'(O_IDLE));
`else
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            ifc.ph2_en = 1'b1; tick();
            if (outs() !== w_exp(2'b10)) bad++;
            ifc.ph2_en = 1'b0; tick();
        end
        chk("no timeout", 32'(bad), 32'd0);
        finish(2'b10, 1'b0, "long wait");
`endif

        // rst mid-service: immediate idle, pend dropped
        nmi_edge();
        take(2'b10, "rst mid");
        rst = 1'b1; tick();
        chk("rst mid outs", 32'(outs()), 32'(O_IDLE));
        rst = 1'b0; tick(4);
        sync_idle("rst mid pend");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
